// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two requesters share one external combinational ALU.
// Each port has a request channel and a one-entry registered response buffer.
// A round-robin or fixed-priority grant picks at most one request per cycle.
//
// Handshake semantics (all channels): a transfer happens on a rising edge
// where valid & ready are both high. A producer never waits for ready before
// raising valid. Ready may depend on valid, but valid never depends on ready.
// Once raised, rsp*_valid and its payload stay stable until the transfer.
module alu_share_arbiter #(
  parameter int XLEN        = 32,
  parameter bit P0_PRIORITY = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  // port 0: core execute stage
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [3:0]      req0_ctrl,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_data,
  output logic            rsp0_zero,
  output logic            rsp0_err,
  // port 1: address-generation / auxiliary unit
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [3:0]      req1_ctrl,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_data,
  output logic            rsp1_zero,
  output logic            rsp1_err,
  // shared ALU
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result
);

  // Highest legal ALUControl code (sltu); everything above is illegal.
  localparam logic [3:0] CTRL_MAX = 4'd9;

  // Response buffers and arbitration history.
  logic            rsp0_valid_q, rsp1_valid_q;
  logic [XLEN-1:0] rsp0_data_q,  rsp1_data_q;
  logic            rsp0_zero_q,  rsp1_zero_q;
  logic            rsp0_err_q,   rsp1_err_q;
  logic            rr_last_q;

  logic            elig0, elig1;
  logic            want0, want1;
  logic            p0_wins_tie;
  logic            grant0, grant1;
  logic [3:0]      sel_ctrl;
  logic            sel_illegal;
  logic [XLEN-1:0] result;

  // A port can take a new op if its buffer is empty or is draining this cycle.
  assign elig0 = !rsp0_valid_q || rsp0_ready;
  assign elig1 = !rsp1_valid_q || rsp1_ready;
  assign want0 = elig0 && req0_valid;
  assign want1 = elig1 && req1_valid;

  // Port 0 wins a tie under fixed priority, or when port 1 was served last.
  assign p0_wins_tie = P0_PRIORITY || rr_last_q;

  assign grant0 = want0 && (!want1 || p0_wins_tie);
  assign grant1 = want1 && !(want0 && p0_wins_tie);

  // Ready tells each port whether it would be granted if it asserted valid.
  assign req0_ready = elig0 && (!want1 || p0_wins_tie);
  assign req1_ready = elig1 && !(want0 && p0_wins_tie);

  // Steer the granted operands to the ALU; illegal codes run as add.
  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    sel_ctrl    = 4'd0;
    if (grant0) begin
      alu_a    = req0_a;
      alu_b    = req0_b;
      sel_ctrl = req0_ctrl;
    end else if (grant1) begin
      alu_a    = req1_a;
      alu_b    = req1_b;
      sel_ctrl = req1_ctrl;
    end
    sel_illegal = sel_ctrl > CTRL_MAX;
    alu_ctrl    = sel_illegal ? 4'd0 : sel_ctrl;
    result      = sel_illegal ? '0 : alu_result;
  end

  // Capture the ALU result into the granted port's buffer; drain on handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp0_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp0_zero_q  <= 1'b0;
      rsp0_err_q   <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp1_data_q  <= '0;
      rsp1_zero_q  <= 1'b0;
      rsp1_err_q   <= 1'b0;
      rr_last_q    <= 1'b1;
    end else begin
      if (grant0) begin
        rsp0_valid_q <= 1'b1;
        rsp0_data_q  <= result;
        rsp0_zero_q  <= (result == '0);
        rsp0_err_q   <= sel_illegal;
        rr_last_q    <= 1'b0;
      end else if (rsp0_valid_q && rsp0_ready) begin
        rsp0_valid_q <= 1'b0;
      end
      if (grant1) begin
        rsp1_valid_q <= 1'b1;
        rsp1_data_q  <= result;
        rsp1_zero_q  <= (result == '0);
        rsp1_err_q   <= sel_illegal;
        rr_last_q    <= 1'b1;
      end else if (rsp1_valid_q && rsp1_ready) begin
        rsp1_valid_q <= 1'b0;
      end
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp0_zero  = rsp0_zero_q;
  assign rsp0_err   = rsp0_err_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_data  = rsp1_data_q;
  assign rsp1_zero  = rsp1_zero_q;
  assign rsp1_err   = rsp1_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a round-robin instance driven from a vector
// table, plus hand sequences for reset mid-operation and a fixed-priority
// instance sharing the same request inputs.
module tb_alu_share_arbiter;

  localparam int XLEN = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic            req0_valid, req1_valid;
  logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]      req0_ctrl, req1_ctrl;
  logic            rsp0_ready, rsp1_ready;

  // round-robin instance outputs
  logic            rr_req0_ready, rr_req1_ready;
  logic            rr_rsp0_valid, rr_rsp1_valid;
  logic [XLEN-1:0] rr_rsp0_data, rr_rsp1_data;
  logic            rr_rsp0_zero, rr_rsp1_zero, rr_rsp0_err, rr_rsp1_err;
  logic [XLEN-1:0] rr_alu_a, rr_alu_b, rr_alu_result;
  logic [3:0]      rr_alu_ctrl;

  // fixed-priority instance outputs
  logic            fp_req0_ready, fp_req1_ready;
  logic            fp_rsp0_valid, fp_rsp1_valid;
  logic [XLEN-1:0] fp_rsp0_data, fp_rsp1_data;
  logic            fp_rsp0_zero, fp_rsp1_zero, fp_rsp0_err, fp_rsp1_err;
  logic [XLEN-1:0] fp_alu_a, fp_alu_b, fp_alu_result;
  logic [3:0]      fp_alu_ctrl;

  // Reference ALU standing in for the shared execution unit.
  function automatic logic [XLEN-1:0] alu_f(input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b,
                                            input logic [3:0] c);
    case (c)
      4'd0: alu_f = a + b;
      4'd1: alu_f = a - b;
      4'd2: alu_f = a & b;
      4'd3: alu_f = a | b;
      4'd4: alu_f = a << b[4:0];
      4'd5: alu_f = {31'd0, $signed(a) < $signed(b)};
      4'd6: alu_f = a >> b[4:0];
      4'd7: alu_f = a ^ b;
      4'd8: alu_f = $signed(a) >>> b[4:0];
      4'd9: alu_f = {31'd0, a < b};
      default: alu_f = 32'hDEAD_BEEF;
    endcase
  endfunction

  assign rr_alu_result = alu_f(rr_alu_a, rr_alu_b, rr_alu_ctrl);
  assign fp_alu_result = alu_f(fp_alu_a, fp_alu_b, fp_alu_ctrl);

  alu_share_arbiter #(.XLEN(XLEN), .P0_PRIORITY(1'b0)) dut_rr (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(rr_req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .rsp0_valid(rr_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rr_rsp0_data),
    .rsp0_zero(rr_rsp0_zero), .rsp0_err(rr_rsp0_err),
    .req1_valid(req1_valid), .req1_ready(rr_req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .rsp1_valid(rr_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rr_rsp1_data),
    .rsp1_zero(rr_rsp1_zero), .rsp1_err(rr_rsp1_err),
    .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_ctrl(rr_alu_ctrl),
    .alu_result(rr_alu_result)
  );

  alu_share_arbiter #(.XLEN(XLEN), .P0_PRIORITY(1'b1)) dut_fp (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .rsp0_valid(fp_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(fp_rsp0_data),
    .rsp0_zero(fp_rsp0_zero), .rsp0_err(fp_rsp0_err),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .rsp1_valid(fp_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(fp_rsp1_data),
    .rsp1_zero(fp_rsp1_zero), .rsp1_err(fp_rsp1_err),
    .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_ctrl(fp_alu_ctrl),
    .alu_result(fp_alu_result)
  );

  // ---------------- scoreboard ----------------
  int n_total  = 0;
  int n_passed = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    else
      n_passed++;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v0, input logic [XLEN-1:0] a0,
                       input logic [XLEN-1:0] b0, input logic [3:0] c0,
                       input logic v1, input logic [XLEN-1:0] a1,
                       input logic [XLEN-1:0] b1, input logic [3:0] c1,
                       input logic r0, input logic r1);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_ctrl = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_ctrl = c1;
    rsp0_ready = r0; rsp1_ready = r1;
  endtask

  typedef struct {
    logic            v0;
    logic [XLEN-1:0] a0, b0;
    logic [3:0]      c0;
    logic            v1;
    logic [XLEN-1:0] a1, b1;
    logic [3:0]      c1;
    logic            r0, r1;
    // expected during the cycle
    logic            e_rdy0, e_rdy1;
    logic [3:0]      e_ctrl;
    logic [XLEN-1:0] e_alu_a;
    // expected after the edge
    logic            e_v0;
    logic [XLEN-1:0] e_d0;
    logic            e_z0, e_e0;
    logic            e_v1;
    logic [XLEN-1:0] e_d1;
    logic            e_z1, e_e1;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  // Apply one vector for one cycle; combinational checks mid-cycle,
  // response checks just after the edge (payload only when valid).
  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    drive(v.v0, v.a0, v.b0, v.c0, v.v1, v.a1, v.b1, v.c1, v.r0, v.r1);
    #4;
    chk($sformatf("v%0d.req0_ready", i), {31'd0, rr_req0_ready}, {31'd0, v.e_rdy0});
    chk($sformatf("v%0d.req1_ready", i), {31'd0, rr_req1_ready}, {31'd0, v.e_rdy1});
    chk($sformatf("v%0d.alu_ctrl", i), {28'd0, rr_alu_ctrl}, {28'd0, v.e_ctrl});
    chk($sformatf("v%0d.alu_a", i), rr_alu_a, v.e_alu_a);
    @(posedge clk); #1;
    chk($sformatf("v%0d.rsp0_valid", i), {31'd0, rr_rsp0_valid}, {31'd0, v.e_v0});
    if (v.e_v0) begin
      chk($sformatf("v%0d.rsp0_data", i), rr_rsp0_data, v.e_d0);
      chk($sformatf("v%0d.rsp0_zero", i), {31'd0, rr_rsp0_zero}, {31'd0, v.e_z0});
      chk($sformatf("v%0d.rsp0_err", i), {31'd0, rr_rsp0_err}, {31'd0, v.e_e0});
    end
    chk($sformatf("v%0d.rsp1_valid", i), {31'd0, rr_rsp1_valid}, {31'd0, v.e_v1});
    if (v.e_v1) begin
      chk($sformatf("v%0d.rsp1_data", i), rr_rsp1_data, v.e_d1);
      chk($sformatf("v%0d.rsp1_zero", i), {31'd0, rr_rsp1_zero}, {31'd0, v.e_z1});
      chk($sformatf("v%0d.rsp1_err", i), {31'd0, rr_rsp1_err}, {31'd0, v.e_e1});
    end
  endtask

  // ---------------- test ----------------
  initial begin
    //            v0  a0            b0            c0    v1  a1            b1            c1    r0  r1   rdy0 rdy1 ctrl  alu_a          v0  d0            z0  e0    v1  d1            z1  e1
    // single port 0 sub 5-3
    vecs[0]  = '{1, 32'd5,        32'd3,        4'd1, 0, 32'd0,        32'd0,        4'd0, 1, 1,  1, 0, 4'd1, 32'd5,        1, 32'd2,        0, 0,  0, 32'd0,        0, 0};
    // contention, rr alternates: port 1, 0, 1
    vecs[1]  = '{1, 32'd10,       32'd20,       4'd0, 1, 32'd100,      32'd1,        4'd0, 1, 1,  0, 1, 4'd0, 32'd100,      0, 32'd0,        0, 0,  1, 32'd101,      0, 0};
    vecs[2]  = '{1, 32'd10,       32'd20,       4'd0, 1, 32'd100,      32'd1,        4'd0, 1, 1,  1, 0, 4'd0, 32'd10,       1, 32'd30,       0, 0,  0, 32'd0,        0, 0};
    vecs[3]  = '{1, 32'd10,       32'd20,       4'd0, 1, 32'd100,      32'd1,        4'd0, 1, 1,  0, 1, 4'd0, 32'd100,      0, 32'd0,        0, 0,  1, 32'd101,      0, 0};
    // port 0 7-7 = 0, then consumer stalls
    vecs[4]  = '{1, 32'd7,        32'd7,        4'd1, 0, 32'd0,        32'd0,        4'd0, 1, 1,  1, 0, 4'd1, 32'd7,        1, 32'd0,        1, 0,  0, 32'd0,        0, 0};
    vecs[5]  = '{1, 32'd7,        32'd7,        4'd1, 1, 32'd1,        32'h8000_0000, 4'd9, 0, 1,  0, 1, 4'd9, 32'd1,        1, 32'd0,        1, 0,  1, 32'd1,        0, 0};
    vecs[6]  = '{1, 32'd7,        32'd7,        4'd1, 1, 32'd1,        32'h8000_0000, 4'd9, 0, 1,  0, 1, 4'd9, 32'd1,        1, 32'd0,        1, 0,  1, 32'd1,        0, 0};
    vecs[7]  = '{1, 32'd7,        32'd7,        4'd1, 1, 32'hFFFF_FFFF, 32'd1,        4'd5, 0, 1,  0, 1, 4'd5, 32'hFFFF_FFFF, 1, 32'd0,        1, 0,  1, 32'd1,        0, 0};
    // port 0 drains; illegal code on port 1
    vecs[8]  = '{0, 32'd0,        32'd0,        4'd0, 1, 32'd3,        32'd4,        4'd12, 1, 1,  1, 1, 4'd0, 32'd3,        0, 32'd0,        0, 0,  1, 32'd0,        1, 1};
    vecs[9]  = '{0, 32'd0,        32'd0,        4'd0, 1, 32'hF0,       32'hFF,       4'd7, 1, 1,  1, 1, 4'd7, 32'hF0,       0, 32'd0,        0, 0,  1, 32'h0F,       0, 0};
    // port 1 stalled with a pending request: no grant, response held
    vecs[10] = '{0, 32'd0,        32'd0,        4'd0, 1, 32'd1,        32'd1,        4'd0, 1, 0,  1, 0, 4'd0, 32'd0,        0, 32'd0,        0, 0,  1, 32'h0F,       0, 0};
    vecs[11] = '{1, 32'h8000_0000, 32'd4,        4'd8, 1, 32'd1,        32'd1,        4'd0, 1, 0,  1, 0, 4'd8, 32'h8000_0000, 1, 32'hF800_0000, 0, 0,  1, 32'h0F,       0, 0};
    // idle drains both
    vecs[12] = '{0, 32'd0,        32'd0,        4'd0, 0, 32'd0,        32'd0,        4'd0, 1, 1,  1, 1, 4'd0, 32'd0,        0, 32'd0,        0, 0,  0, 32'd0,        0, 0};
    // contention with rr_last=0: port 1 (srl) wins
    vecs[13] = '{1, 32'd1,        32'd31,       4'd4, 1, 32'h8000_0000, 32'd31,       4'd6, 1, 1,  0, 1, 4'd6, 32'h8000_0000, 0, 32'd0,        0, 0,  1, 32'd1,        0, 0};

    // reset
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #3;
    chk("reset.rsp0_valid", {31'd0, rr_rsp0_valid}, 32'd0);
    chk("reset.rsp0_data",  rr_rsp0_data, 32'd0);
    chk("reset.rsp0_zero",  {31'd0, rr_rsp0_zero}, 32'd0);
    chk("reset.rsp0_err",   {31'd0, rr_rsp0_err}, 32'd0);
    chk("reset.rsp1_valid", {31'd0, rr_rsp1_valid}, 32'd0);
    chk("reset.rsp1_data",  rr_rsp1_data, 32'd0);
    chk("reset.req0_ready", {31'd0, rr_req0_ready}, 32'd1);
    chk("reset.req1_ready", {31'd0, rr_req1_ready}, 32'd1);
    chk("reset.alu_ctrl",   {28'd0, rr_alu_ctrl}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) run_vec(i);

    // Reset the cycle after an acceptance while rsp0 is valid.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    @(posedge clk); #1;
    drive(1, 32'd2, 32'd2, 4'd0, 0, 0, 0, 0, 1, 1);
    @(posedge clk); #1;
    chk("rst_mid.pre_valid", {31'd0, rr_rsp0_valid}, 32'd1);
    chk("rst_mid.pre_data",  rr_rsp0_data, 32'd4);
    drive(1, 32'd6, 32'd6, 4'd0, 1, 32'd9, 32'd9, 4'd0, 0, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid.rsp0_valid", {31'd0, rr_rsp0_valid}, 32'd0);
    chk("rst_mid.rsp1_valid", {31'd0, rr_rsp1_valid}, 32'd0);
    reset = 1'b0;
    drive(1, 32'd6, 32'd6, 4'd0, 1, 32'd9, 32'd9, 4'd0, 1, 1);
    #4;
    chk("rst_mid.req0_ready", {31'd0, rr_req0_ready}, 32'd1);
    chk("rst_mid.req1_ready", {31'd0, rr_req1_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rst_mid.post_v0", {31'd0, rr_rsp0_valid}, 32'd1);
    chk("rst_mid.post_d0", rr_rsp0_data, 32'd12);
    chk("rst_mid.post_v1", {31'd0, rr_rsp1_valid}, 32'd0);

    // Both ports valid every cycle: rr alternates 1,0,1,0 from here;
    // fixed priority grants port 0 every cycle.
    for (int k = 0; k < 4; k++) begin
      drive(1, k, 32'd1, 4'd0, 1, 32'd50 + k, 32'd0, 4'd0, 1, 1);
      #4;
      chk($sformatf("alt%0d.rr_req0_ready", k), {31'd0, rr_req0_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("alt%0d.rr_req1_ready", k), {31'd0, rr_req1_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("alt%0d.fp_req0_ready", k), {31'd0, fp_req0_ready}, 32'd1);
      chk($sformatf("alt%0d.fp_req1_ready", k), {31'd0, fp_req1_ready}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("alt%0d.rr_rsp1_valid", k), {31'd0, rr_rsp1_valid}, (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k % 2 == 0) chk($sformatf("alt%0d.rr_rsp1_data", k), rr_rsp1_data, 32'd50 + k);
      chk($sformatf("alt%0d.fp_rsp0_valid", k), {31'd0, fp_rsp0_valid}, 32'd1);
      chk($sformatf("alt%0d.fp_rsp0_data", k), fp_rsp0_data, k + 1);
      chk($sformatf("alt%0d.fp_rsp1_valid", k), {31'd0, fp_rsp1_valid}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU between two requesters: port 0 is the core execute stage, port 1 is the address-generation/auxiliary unit.
- Each port has valid/ready request and response channels.
- Round-robin arbitration, one operation per cycle, result registered into a one-entry response buffer per port.
- Sits between the requesters and the shared ALU. Drives the ALU operand and control inputs, and samples its result in the same cycle.

Parameters:
- XLEN, 32, operand/result width
- P0_PRIORITY, 0, if 1 port 0 always wins contention (fixed priority); if 0, round-robin

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  port 0 request valid
- req0_ready  output  1  port 0 request accepted this cycle when high with req0_valid
- req0_a  input  XLEN  port 0 operand A
- req0_b  input  XLEN  port 0 operand B
- req0_ctrl  input  4  port 0 ALUControl code
- rsp0_valid  output  1  port 0 response valid
- rsp0_ready  input  1  port 0 consumer ready
- rsp0_data  output  XLEN  port 0 result
- rsp0_zero  output  1  port 0 result==0
- rsp0_err  output  1  port 0 illegal ctrl code
- req1_valid, req1_ready, req1_a, req1_b, req1_ctrl, rsp1_valid, rsp1_ready, rsp1_data, rsp1_zero, rsp1_err: same as port 0, for port 1
- alu_a  output  XLEN  shared ALU operand A
- alu_b  output  XLEN  shared ALU operand B
- alu_ctrl  output  4  shared ALU control
- alu_result  input  XLEN  shared ALU result (combinational from alu_a/b/ctrl)

Behaviour:
- Legal ctrl codes:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 sll, 0101 slt
  - 0110 srl, 0111 xor, 1000 sra, 1001 sltu
  - 1010-1111 illegal
- Reset (sync):
  - all rsp*_valid=0, rsp*_data=0, rsp*_zero=0, rsp*_err=0
  - rr_last=1, so port 0 wins the first contention
  - req*_ready reflect eligibility combinationally from reset state
- Eligibility: port i is eligible when rsp_i buffer is empty, or rsp_i_valid & rsp_i_ready in this cycle (drain-and-refill).
- Grant, combinational, at most one port per cycle:
  - only one eligible port with valid: grant it
  - both eligible with valid, P0_PRIORITY=1: grant port 0
  - both eligible with valid, P0_PRIORITY=0: grant the port not equal to rr_last
- req_i_ready = eligible_i & (grant would go to i if req_i_valid); the loser sees ready=0.
- Ready may depend on valid; no valid may depend on ready.
- ALU drive:
  - granted port: alu_a/alu_b/alu_ctrl = its operands
  - no grant: alu_a=0, alu_b=0, alu_ctrl=0000
  - granted ctrl illegal: alu_ctrl=0000, operands still driven
- Handshake at edge N, port i accepted:
  - rsp_i_valid=1 at N+1
  - rsp_i_data = alu_result, or 0 if ctrl illegal
  - rsp_i_zero = (rsp_i_data==0)
  - rsp_i_err = illegal
  - rr_last <= i
- Latency: exactly one cycle request-to-response. Throughput: one op per port per cycle when the consumer holds ready=1.
- Response hold: while rsp_i_valid & !rsp_i_ready, data/zero/err are stable. The buffer clears on handshake unless refilled in the same cycle.
- Backpressure: a stalled port leaves the other port free to use the ALU every cycle; no starvation.
- Reset mid-operation: pending responses are discarded, no response emitted for operations accepted in the reset cycle.
- Simultaneous drain and accept on same port: new result replaces old; rsp_valid stays 1.

Test Plan:
- Single port 0, a=5, b=3, ctrl=0001, rsp0_ready=1
  -> req0_ready=1 in cycle 0; cycle 1: rsp0_valid=1, data=2, zero=0, err=0; alu_ctrl=0001 in cycle 0.
- Both valid every cycle, P0_PRIORITY=0, ready=1, both ctrl=0000
  -> grants alternate 0,1,0,1; each port gets one response every other cycle; port 0 first after reset.
- Same stimulus with P0_PRIORITY=1
  -> port 0 granted every cycle; req1_ready=0 throughout.
- Port 0 stall: rsp0_ready=0 after first response (a=7, b=7, ctrl=0001)
  -> rsp0 holds data=0, zero=1; req0_ready=0; port 1 ops (a=1, b=0x8000_0000, ctrl=1001) complete every cycle with data=1.
- Illegal ctrl=1100 on port 1
  -> alu_ctrl=0000 that cycle; next cycle rsp1_valid=1, data=0, zero=1, err=1.
- Reset asserted the cycle after acceptance, with rsp0_valid=1
  -> rsp0_valid=0 on next edge; after reset release, first contention grants port 0.
